instr_issue_ctrl: RTL and testbench

Sequencer between the fetch buffer and the decoder/pipeline registers. It owns the program counter and accepts 49-bit instructions over a valid/ready handshake. It forwards accepted instructions to the decode stage and stalls issue on read-after-write hazards against in-flight destination registers. It also executes the control ops NOP, JMP and HALT locally.

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/issue_scoreboard.sv | 70 +++++++
 rtl/instr_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the instruction issue controller: instruction field
// positions, control opcodes, mode-bit meaning and the issue FSM state type.
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int INSTR_W = 49;
    localparam int REG_W   = 5;

    // Instruction layout: op | mode | src | dst | lit
    localparam int OP_HI   = 48;
    localparam int OP_LO   = 44;
    localparam int MODE_HI = 43;
    localparam int MODE_LO = 42;
    localparam int SRC_HI  = 41;
    localparam int SRC_LO  = 37;
    localparam int DST_HI  = 36;
    localparam int DST_LO  = 32;
    localparam int LIT_HI  = 31;
    localparam int LIT_LO  = 0;

    // mode[MODE_LIT_BIT]=1 means the literal replaces the src register
    localparam int MODE_LIT_BIT = 0;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_JMP  = 5'h1E;
    localparam logic [4:0] OP_HALT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Control ops are executed locally: they neither read nor write registers.
    function automatic logic is_ctrl_op(input logic [4:0] op);
        return (op == OP_NOP) || (op == OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// Fixed-latency in-flight destination tracker. One {valid, dst} entry is
// inserted every cycle and shifts towards the oldest slot, so a written
// register is considered busy for exactly DEPTH cycles after its insert edge.
//
// Ports:
//   clk, rst_n          clock / async active-low reset
//   ins_v, ins_dst      entry inserted this cycle (ins_v=0 inserts a bubble)
//   rd_src_en, rd_src   src register read by the candidate instruction
//   rd_dst_en, rd_dst   dst register read by the candidate instruction
//   hazard              a valid in-flight entry matches an enabled read
//   empty               no entry survives the coming edge (only the oldest
//                       slot, which is about to retire, may still be valid)
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int DEPTH = 3,
    parameter int RW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ins_v,
    input  logic [RW-1:0] ins_dst,
    input  logic          rd_src_en,
    input  logic [RW-1:0] rd_src,
    input  logic          rd_dst_en,
    input  logic [RW-1:0] rd_dst,
    output logic          hazard,
    output logic          empty
);

    // Index 0 is the newest entry, DEPTH-1 the oldest.
    logic [DEPTH-1:0]          r_vld_pipe;
    logic [DEPTH-1:0][RW-1:0]  r_dst_pipe;
    logic [DEPTH-1:0]          w_hit;
    logic                      w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_dst_pipe <= '0;
        end else begin
            for (int i = DEPTH-1; i > 0; i--) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_dst_pipe[i] <= r_dst_pipe[i-1];
            end
            r_vld_pipe[0] <= ins_v;
            r_dst_pipe[0] <= ins_dst;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_hit[g] = r_vld_pipe[g] &&
                          ((rd_src_en && (r_dst_pipe[g] == rd_src)) ||
                           (rd_dst_en && (r_dst_pipe[g] == rd_dst)));
    end

    // Look-ahead emptiness lets the drain finish on the same edge that
    // retires the last busy entry.
    always_comb begin
        w_empty = 1'b1;
        for (int i = 0; i < DEPTH-1; i++) begin
            if (r_vld_pipe[i]) w_empty = 1'b0;
        end
    end

    assign hazard = |w_hit;
    assign empty  = w_empty;

endmodule

// File: rtl/instr_issue_ctrl.sv
// -----------------------------------------------------------------------------
// instr_issue_ctrl
// Issue sequencer between the fetch buffer and the decoder. Owns the PC,
// accepts instructions over valid/ready, forwards ordinary ops one cycle
// after accept, stalls on RAW hazards against in-flight destinations and
// executes NOP / JMP / HALT locally.
//
// Ports:
//   clk, rst_n           clock / async active-low reset
//   run                  start / resume (IDLE or HALTED -> RUN)
//   pc                   next fetch address
//   fetch_en             high while in RUN
//   flush                one-cycle pulse after an accepted JMP
//   instr_in/valid/ready instruction handshake from the fetch buffer
//   issue_instr/valid    registered instruction to decode, one-cycle valid
//   stall                RUN with a valid instruction blocked by a hazard
//   halted               high in HALTED
// -----------------------------------------------------------------------------
module instr_issue_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int IW         = INSTR_W,
    parameter int PC_W       = 16,
    parameter int PIPE_DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic            flush,
    input  logic [IW-1:0]   instr_in,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [IW-1:0]   issue_instr,
    output logic            issue_valid,
    output logic            stall,
    output logic            halted
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_flush;
    logic              r_issue_valid;
    logic [IW-1:0]     r_issue_instr;

    logic [4:0]        w_op;
    logic [REG_W-1:0]  w_src;
    logic [REG_W-1:0]  w_dst;
    logic              w_ctrl;
    logic              w_rd_src_en;
    logic              w_rd_dst_en;
    logic              w_hazard;
    logic              w_sb_empty;
    logic              w_ready;
    logic              w_accept;
    logic              w_ins_v;

    assign w_op  = instr_in[OP_HI:OP_LO];
    assign w_src = instr_in[SRC_HI:SRC_LO];
    assign w_dst = instr_in[DST_HI:DST_LO];

    // Two-operand ops always read dst; src only when no literal is used.
    assign w_ctrl      = is_ctrl_op(w_op);
    assign w_rd_dst_en = !w_ctrl;
    assign w_rd_src_en = !w_ctrl && !instr_in[MODE_LO + MODE_LIT_BIT];

    assign w_ready  = (r_state == RUN) && !w_hazard && !r_flush;
    assign w_accept = instr_valid && w_ready;
    // Every cycle inserts into the scoreboard; only accepted writers are valid.
    assign w_ins_v  = w_accept && !w_ctrl;

    issue_scoreboard #(
        .DEPTH (PIPE_DEPTH),
        .RW    (REG_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins_v     (w_ins_v),
        .ins_dst   (w_dst),
        .rd_src_en (w_rd_src_en),
        .rd_src    (w_src),
        .rd_dst_en (w_rd_dst_en),
        .rd_dst    (w_dst),
        .hazard    (w_hazard),
        .empty     (w_sb_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_flush       <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
        end else begin
            r_flush       <= 1'b0;
            r_issue_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run) r_state <= RUN;
                end
                RUN: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_NOP: begin
                                r_pc <= r_pc + 1'b1;
                            end
                            OP_JMP: begin
                                r_pc    <= instr_in[LIT_LO +: PC_W];
                                r_flush <= 1'b1;
                            end
                            OP_HALT: begin
                                r_pc    <= r_pc + 1'b1;
                                r_state <= DRAIN;
                            end
                            default: begin
                                r_pc          <= r_pc + 1'b1;
                                r_issue_instr <= instr_in;
                                r_issue_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                DRAIN: begin
                    if (w_sb_empty) r_state <= HALTED;
                end
                HALTED: begin
                    if (run) r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pc          = r_pc;
    assign fetch_en    = (r_state == RUN);
    assign halted      = (r_state == HALTED);
    assign flush       = r_flush;
    assign instr_ready = w_ready;
    assign issue_instr = r_issue_instr;
    assign issue_valid = r_issue_valid;
    assign stall       = (r_state == RUN) && instr_valid && w_hazard;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
module tb_instr_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] pc;
    logic        fetch_en;
    logic        flush;
    logic [48:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [48:0] issue_instr;
    logic        issue_valid;
    logic        stall;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .issue_instr (issue_instr),
        .issue_valid (issue_valid),
        .stall       (stall),
        .halted      (halted)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [48:0] mk(input logic [4:0] op, input logic [1:0] mode,
                                       input logic [4:0] src, input logic [4:0] dst,
                                       input logic [31:0] lit);
        return {op, mode, src, dst, lit};
    endfunction

    // Advance one clock; inputs are changed and outputs checked 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_run();
        rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr_in = '0;
        step(); step();
        rst_n = 1'b1; run = 1'b1;
        step();
        run = 1'b0;
    endtask

    logic [48:0] i1, i2, i3, p, d, w;

    initial begin
        rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr_in = '0;
        #3;
        // ---- reset state
        chk("rst_pc", pc, 0);
        chk("rst_fetch_en", fetch_en, 0);
        chk("rst_flush", flush, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_instr", issue_instr, 0);
        chk("rst_halted", halted, 0);

        // ---- three independent instructions, back to back
        reset_run();
        chk("run_fetch_en", fetch_en, 1);
        i1 = mk(5'h01, 2'b01, 5'd0, 5'd1, 32'h11);
        i2 = mk(5'h01, 2'b01, 5'd0, 5'd2, 32'h22);
        i3 = mk(5'h01, 2'b01, 5'd0, 5'd3, 32'h33);
        instr_valid = 1'b1; instr_in = i1; settle();
        chk("ind_stall0", stall, 0);
        chk("ind_ready0", instr_ready, 1);
        step(); instr_in = i2; settle();
        chk("ind_iv1", issue_valid, 1);
        chk("ind_ii1", issue_instr, i1);
        chk("ind_stall1", stall, 0);
        step(); instr_in = i3; settle();
        chk("ind_iv2", issue_valid, 1);
        chk("ind_ii2", issue_instr, i2);
        chk("ind_stall2", stall, 0);
        step(); instr_valid = 1'b0; settle();
        chk("ind_iv3", issue_valid, 1);
        chk("ind_ii3", issue_instr, i3);
        chk("ind_pc", pc, 3);
        step();
        chk("ind_iv_end", issue_valid, 0);

        // ---- RAW hazard: dependent directly behind producer
        reset_run();
        p = mk(5'h01, 2'b01, 5'd0, 5'd4, 32'h0);
        d = mk(5'h02, 2'b00, 5'd4, 5'd5, 32'h0);
        instr_valid = 1'b1; instr_in = p;
        step(); instr_in = d; settle();
        chk("raw_iv_p", issue_valid, 1);
        chk("raw_stall_c0", stall, 1);
        chk("raw_ready_c0", instr_ready, 0);
        step();
        chk("raw_stall_c1", stall, 1);
        chk("raw_iv_c1", issue_valid, 0);
        step();
        chk("raw_stall_c2", stall, 1);
        step();
        chk("raw_stall_c3", stall, 0);
        chk("raw_ready_c3", instr_ready, 1);
        step(); instr_valid = 1'b0; settle();
        chk("raw_iv_d", issue_valid, 1);
        chk("raw_ii_d", issue_instr, d);
        chk("raw_pc", pc, 2);

        // ---- JMP at pc=5
        reset_run();
        instr_valid = 1'b1; instr_in = mk(5'h00, 2'b00, 5'd0, 5'd0, 32'h0);
        for (int k = 0; k < 5; k++) step();
        chk("nop_pc", pc, 5);
        chk("nop_iv", issue_valid, 0);
        instr_in = mk(5'h1E, 2'b01, 5'd0, 5'd0, 32'h0000_0040);
        step(); instr_in = mk(5'h01, 2'b01, 5'd0, 5'd6, 32'h0); settle();
        chk("jmp_pc", pc, 16'h0040);
        chk("jmp_flush", flush, 1);
        chk("jmp_ready", instr_ready, 0);
        chk("jmp_iv", issue_valid, 0);
        step();
        chk("jmp_flush_end", flush, 0);
        chk("jmp_pc_hold", pc, 16'h0040);
        chk("jmp_ready_after", instr_ready, 1);
        instr_valid = 1'b0;

        // ---- writer then HALT: drain then resume
        reset_run();
        w = mk(5'h01, 2'b01, 5'd0, 5'd7, 32'h0);
        instr_valid = 1'b1; instr_in = w;
        step(); instr_in = mk(5'h1F, 2'b00, 5'd0, 5'd0, 32'h0); settle();
        chk("halt_ready", instr_ready, 1);
        step(); instr_valid = 1'b0; settle();
        chk("drain_fetch_en", fetch_en, 0);
        chk("drain_halted1", halted, 0);
        chk("drain_iv", issue_valid, 0);
        chk("drain_pc", pc, 2);
        step();
        chk("drain_halted2", halted, 0);
        step();
        chk("drain_halted3", halted, 1);
        run = 1'b1;
        step(); run = 1'b0; settle();
        chk("resume_fetch_en", fetch_en, 1);
        chk("resume_halted", halted, 0);
        chk("resume_pc", pc, 2);

        // ---- HALT with empty scoreboard: HALTED after one cycle
        reset_run();
        instr_valid = 1'b1; instr_in = mk(5'h1F, 2'b00, 5'd0, 5'd0, 32'h0);
        step(); instr_valid = 1'b0; settle();
        chk("hempty_drain", halted, 0);
        step();
        chk("hempty_halted", halted, 1);
        chk("hempty_pc", pc, 1);

        // ---- pc wrap
        reset_run();
        instr_valid = 1'b1; instr_in = mk(5'h1E, 2'b01, 5'd0, 5'd0, 32'h0000_FFFF);
        step(); instr_in = mk(5'h03, 2'b01, 5'd0, 5'd8, 32'h0); settle();
        chk("wrap_pc_ffff", pc, 16'hFFFF);
        step();
        step(); instr_valid = 1'b0; settle();
        chk("wrap_pc_0", pc, 16'h0000);
        chk("wrap_iv", issue_valid, 1);

        // ---- async reset mid-stall
        reset_run();
        p = mk(5'h01, 2'b01, 5'd0, 5'd9, 32'h0);
        d = mk(5'h02, 2'b00, 5'd9, 5'd10, 32'h0);
        instr_valid = 1'b1; instr_in = p;
        step(); instr_in = d; settle();
        chk("mid_stall", stall, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_pc", pc, 0);
        chk("mid_fetch_en", fetch_en, 0);
        chk("mid_ready", instr_ready, 0);
        chk("mid_stall0", stall, 0);
        chk("mid_iv", issue_valid, 0);
        chk("mid_ii", issue_instr, 0);
        chk("mid_flush_halt", {flush, halted}, 0);
        step();
        rst_n = 1'b1; run = 1'b1;
        step(); run = 1'b0; settle();
        chk("post_iv", issue_valid, 0);
        chk("post_stall", stall, 0);
        chk("post_ready", instr_ready, 1);
        step(); instr_valid = 1'b0; settle();
        chk("post_iv_d", issue_valid, 1);
        chk("post_ii_d", issue_instr, d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
